// File: rtl/cdb_arbiter.sv
// Common data bus: one small FIFO per execution source, with round-robin grants onto NUM_BUS
// registered result buses.
module cdb_arbiter #(
    parameter int RoB_WIDTH      = 4,
    parameter int NUM_SRC        = 4,
    parameter int NUM_BUS        = 2,
    parameter int FIFO_DEPTH_LOG = 1
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic                          rdy_in,
    input  logic                          flush_signal,
    input  logic [NUM_SRC-1:0]            src_valid,
    output logic [NUM_SRC-1:0]            src_ready,
    input  logic [NUM_SRC*RoB_WIDTH-1:0]  src_index,
    input  logic [NUM_SRC*32-1:0]         src_data,
    output logic [NUM_BUS-1:0]            bus_en,
    output logic [NUM_BUS*RoB_WIDTH-1:0]  bus_index,
    output logic [NUM_BUS*32-1:0]         bus_data,
    output logic                          isEmpty
);

    localparam int unsigned NSRC  = NUM_SRC;
    localparam int unsigned NBUS  = NUM_BUS;
    localparam int unsigned DEPTH = 1 << FIFO_DEPTH_LOG;
    localparam int          AW    = FIFO_DEPTH_LOG;
    localparam int          CNT_W = FIFO_DEPTH_LOG + 1;
    localparam int          PTR_W = $clog2(NUM_SRC);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [RoB_WIDTH-1:0] idx_mem_q [NUM_SRC][DEPTH];
    logic [RoB_WIDTH-1:0] idx_mem_d [NUM_SRC][DEPTH];
    logic [31:0]          dat_mem_q [NUM_SRC][DEPTH];
    logic [31:0]          dat_mem_d [NUM_SRC][DEPTH];
    logic [AW-1:0]        rd_ptr_q [NUM_SRC];
    logic [AW-1:0]        rd_ptr_d [NUM_SRC];
    logic [AW-1:0]        wr_ptr_q [NUM_SRC];
    logic [AW-1:0]        wr_ptr_d [NUM_SRC];
    logic [CNT_W-1:0]     cnt_q [NUM_SRC];
    logic [CNT_W-1:0]     cnt_d [NUM_SRC];
    logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;

    logic [NUM_BUS-1:0]           bus_en_q, bus_en_d;
    logic [NUM_BUS*RoB_WIDTH-1:0] bus_index_q, bus_index_d;
    logic [NUM_BUS*32-1:0]        bus_data_q, bus_data_d;

    logic [NUM_SRC-1:0] non_empty;
    logic [NUM_SRC-1:0] grant;
    logic [PTR_W-1:0]   bus_src [NUM_BUS];
    int unsigned        n_grant;
    int unsigned        last_src;
    int unsigned        pos;

    always_comb begin
        for (int unsigned s = 0; s < NSRC; s++) begin
            src_ready[s] = cnt_q[s] < DEPTH_C;
            non_empty[s] = cnt_q[s] != '0;
        end
    end

    // Walk sources starting at rr_ptr; the k-th non-empty one found is placed on bus k.
    always_comb begin
        grant    = '0;
        n_grant  = 0;
        last_src = 0;
        pos      = 0;
        for (int unsigned b = 0; b < NBUS; b++) bus_src[b] = '0;
        for (int unsigned i = 0; i < NSRC; i++) begin
            pos = (32'(rr_ptr_q) + i) % NSRC;
            for (int unsigned s = 0; s < NSRC; s++) begin
                if (s == pos && non_empty[s] && n_grant < NBUS) begin
                    grant[s] = 1'b1;
                    for (int unsigned b = 0; b < NBUS; b++) begin
                        if (b == n_grant) bus_src[b] = PTR_W'(s);
                    end
                    last_src = s;
                    n_grant  = n_grant + 1;
                end
            end
        end
    end

    always_comb begin
        idx_mem_d   = idx_mem_q;
        dat_mem_d   = dat_mem_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        cnt_d       = cnt_q;
        rr_ptr_d    = rr_ptr_q;
        bus_en_d    = bus_en_q;
        bus_index_d = bus_index_q;
        bus_data_d  = bus_data_q;
        if (rdy_in) begin
            if (flush_signal) begin
                for (int unsigned s = 0; s < NSRC; s++) begin
                    rd_ptr_d[s] = '0;
                    wr_ptr_d[s] = '0;
                    cnt_d[s]    = '0;
                end
                rr_ptr_d    = '0;
                bus_en_d    = '0;
                bus_index_d = '0;
                bus_data_d  = '0;
            end else begin
                for (int unsigned s = 0; s < NSRC; s++) begin
                    if (src_valid[s] && src_ready[s]) begin
                        idx_mem_d[s][wr_ptr_q[s]] = src_index[s*RoB_WIDTH +: RoB_WIDTH];
                        dat_mem_d[s][wr_ptr_q[s]] = src_data[s*32 +: 32];
                        wr_ptr_d[s] = wr_ptr_q[s] + AW'(1);
                    end
                    if (grant[s]) rd_ptr_d[s] = rd_ptr_q[s] + AW'(1);
                    if ((src_valid[s] && src_ready[s]) && !grant[s])
                        cnt_d[s] = cnt_q[s] + CNT_W'(1);
                    else if (!(src_valid[s] && src_ready[s]) && grant[s])
                        cnt_d[s] = cnt_q[s] - CNT_W'(1);
                end
                for (int unsigned b = 0; b < NBUS; b++) begin
                    bus_en_d[b]                       = b < n_grant;
                    bus_index_d[b*RoB_WIDTH +: RoB_WIDTH] = '0;
                    bus_data_d[b*32 +: 32]            = '0;
                    for (int unsigned s = 0; s < NSRC; s++) begin
                        if (b < n_grant && bus_src[b] == PTR_W'(s)) begin
                            bus_index_d[b*RoB_WIDTH +: RoB_WIDTH] = idx_mem_q[s][rd_ptr_q[s]];
                            bus_data_d[b*32 +: 32]            = dat_mem_q[s][rd_ptr_q[s]];
                        end
                    end
                end
                if (n_grant != 0) rr_ptr_d = PTR_W'((last_src + 1) % NSRC);
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int unsigned s = 0; s < NSRC; s++) begin
                for (int unsigned d = 0; d < DEPTH; d++) begin
                    idx_mem_q[s][d] <= '0;
                    dat_mem_q[s][d] <= '0;
                end
                rd_ptr_q[s] <= '0;
                wr_ptr_q[s] <= '0;
                cnt_q[s]    <= '0;
            end
            rr_ptr_q    <= '0;
            bus_en_q    <= '0;
            bus_index_q <= '0;
            bus_data_q  <= '0;
        end else begin
            idx_mem_q   <= idx_mem_d;
            dat_mem_q   <= dat_mem_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            cnt_q       <= cnt_d;
            rr_ptr_q    <= rr_ptr_d;
            bus_en_q    <= bus_en_d;
            bus_index_q <= bus_index_d;
            bus_data_q  <= bus_data_d;
        end
    end

    assign bus_en    = bus_en_q;
    assign bus_index = bus_index_q;
    assign bus_data  = bus_data_q;
    assign isEmpty   = ~|non_empty & ~|bus_en_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: per-source expected queues filled on accepted pushes,
// drained as entries appear on the buses.
module tb_cdb_arbiter;

    logic          clk_in = 1'b0;
    logic          rst_in;
    logic          rdy_in;
    logic          flush_signal;
    logic [3:0]    src_valid;
    logic [3:0]    src_ready;
    logic [15:0]   src_index;
    logic [127:0]  src_data;
    logic [1:0]    bus_en;
    logic [7:0]    bus_index;
    logic [63:0]   bus_data;
    logic          isEmpty;

    cdb_arbiter #(.RoB_WIDTH(4), .NUM_SRC(4), .NUM_BUS(2), .FIFO_DEPTH_LOG(1)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_signal(flush_signal),
        .src_valid(src_valid), .src_ready(src_ready), .src_index(src_index), .src_data(src_data),
        .bus_en(bus_en), .bus_index(bus_index), .bus_data(bus_data), .isEmpty(isEmpty)
    );

    always #5 clk_in = ~clk_in;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    int unsigned seq   = 0;
    logic [35:0] sb [4][$];
    logic [3:0]  stim_idx [4];
    logic [31:0] stim_dat [4];
    bit          saw_full0 = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic gen_stim();
        for (int s = 0; s < 4; s++) begin
            stim_idx[s] = 4'($urandom);
            stim_dat[s] = {8'(8'hA0 + s), 24'(seq)};
            seq++;
        end
    endtask

    function automatic bit model_empty();
        for (int s = 0; s < 4; s++) if (sb[s].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic cycle(input logic [3:0] v, input logic rdy, input logic fl);
        logic [3:0]  mready;
        logic [3:0]  acc;
        int          n_ne;
        int          n_exp;
        logic [1:0]  exp_en;
        logic [1:0]  prev_en;
        logic [7:0]  prev_idx;
        logic [63:0] prev_dat;
        logic [35:0] ent;
        bit          found;
        n_ne = 0;
        for (int s = 0; s < 4; s++) begin
            mready[s] = sb[s].size() < 2;
            if (sb[s].size() != 0) n_ne++;
        end
        check("src_ready", 64'(src_ready), 64'(mready));
        if (!src_ready[0]) saw_full0 = 1'b1;
        acc = v & mready;
        src_valid = acc;
        for (int s = 0; s < 4; s++) begin
            src_index[s*4 +: 4]   = stim_idx[s];
            src_data[s*32 +: 32]  = stim_dat[s];
        end
        rdy_in = rdy;
        flush_signal = fl;
        prev_en  = bus_en;
        prev_idx = bus_index;
        prev_dat = bus_data;
        @(posedge clk_in);
        #1;
        src_valid = '0;
        flush_signal = 1'b0;
        rdy_in = 1'b1;
        if (!rdy) begin
            exp_en = prev_en;
            check("hold_en", 64'(bus_en), 64'(prev_en));
            check("hold_idx", 64'(bus_index), 64'(prev_idx));
            check("hold_dat", bus_data, prev_dat);
        end else if (fl) begin
            exp_en = 2'b00;
            check("flush_en", 64'(bus_en), 64'(0));
            check("flush_idx", 64'(bus_index), 64'(0));
            check("flush_dat", bus_data, 64'(0));
            for (int s = 0; s < 4; s++) sb[s].delete();
        end else begin
            n_exp  = (n_ne > 2) ? 2 : n_ne;
            exp_en = (n_exp == 2) ? 2'b11 : (n_exp == 1) ? 2'b01 : 2'b00;
            check("bus_en", 64'(bus_en), 64'(exp_en));
            for (int b = 0; b < 2; b++) begin
                if (b < n_exp) begin
                    ent = {bus_index[b*4 +: 4], bus_data[b*32 +: 32]};
                    found = 1'b0;
                    for (int s = 0; s < 4; s++) begin
                        if (!found && sb[s].size() != 0 && sb[s][0] == ent) begin
                            void'(sb[s].pop_front());
                            found = 1'b1;
                        end
                    end
                    check("bus_hit", 64'(ent), found ? 64'(ent) : 64'hBAD0_0000_0000);
                end else begin
                    check("idle_idx", 64'(bus_index[b*4 +: 4]), 64'(0));
                    check("idle_dat", 64'(bus_data[b*32 +: 32]), 64'(0));
                end
            end
            for (int s = 0; s < 4; s++)
                if (acc[s]) sb[s].push_back({stim_idx[s], stim_dat[s]});
        end
        check("isEmpty", 64'(isEmpty), 64'(model_empty() && exp_en == 2'b00));
    endtask

    initial begin
        rst_in = 1'b0; rdy_in = 1'b1; flush_signal = 1'b0;
        src_valid = '0; src_index = '0; src_data = '0;
        for (int s = 0; s < 4; s++) begin stim_idx[s] = '0; stim_dat[s] = '0; end
        #12;
        check("rst_en", 64'(bus_en), 64'(0));
        check("rst_idx", 64'(bus_index), 64'(0));
        check("rst_dat", bus_data, 64'(0));
        check("rst_ready", 64'(src_ready), 64'hF);
        check("rst_empty", 64'(isEmpty), 64'(1));
        @(negedge clk_in);
        rst_in = 1'b1;

        // all four sources at once: src0/src1 then src2/src3, pointer back at 0
        for (int pass = 0; pass < 2; pass++) begin
            gen_stim(); cycle(4'b1111, 1'b1, 1'b0);
            gen_stim(); cycle(4'b0000, 1'b1, 1'b0);
            check("rr_b0_first", 64'(bus_data[31:24]), 64'hA0);
            check("rr_b1_first", 64'(bus_data[63:56]), 64'hA1);
            cycle(4'b0000, 1'b1, 1'b0);
            check("rr_b0_second", 64'(bus_data[31:24]), 64'hA2);
            check("rr_b1_second", 64'(bus_data[63:56]), 64'hA3);
            cycle(4'b0000, 1'b1, 1'b0);
        end

        // single source latency
        gen_stim(); stim_idx[2] = 4'd5; stim_dat[2] = 32'hDEADBEEF;
        cycle(4'b0100, 1'b1, 1'b0);
        check("lat_early", 64'(bus_en), 64'(0));
        gen_stim(); cycle(4'b0000, 1'b1, 1'b0);
        check("lat_en", 64'(bus_en), 64'b01);
        check("lat_idx", 64'(bus_index[3:0]), 64'd5);
        check("lat_dat", 64'(bus_data[31:0]), 64'hDEADBEEF);
        cycle(4'b0000, 1'b1, 1'b0);

        // sustained traffic fills FIFO 0
        for (int i = 0; i < 8; i++) begin gen_stim(); cycle(4'b1111, 1'b1, 1'b0); end
        check("fill_src0", 64'(saw_full0), 64'(1));

        // freeze with both buses busy
        check("frz_pre_en", 64'(bus_en), 64'b11);
        for (int i = 0; i < 3; i++) begin gen_stim(); cycle(4'b1111, 1'b0, 1'b0); end
        for (int i = 0; i < 6; i++) begin gen_stim(); cycle(4'b0000, 1'b1, 1'b0); end
        check("frz_drained", 64'(isEmpty), 64'(1));

        // flush with full FIFOs and live pushes
        for (int i = 0; i < 4; i++) begin gen_stim(); cycle(4'b1111, 1'b1, 1'b0); end
        gen_stim(); cycle(4'b1111, 1'b1, 1'b1);
        check("flush_empty", 64'(isEmpty), 64'(1));
        for (int i = 0; i < 3; i++) begin gen_stim(); cycle(4'b0000, 1'b1, 1'b0); end

        // asynchronous reset mid-traffic
        for (int i = 0; i < 3; i++) begin gen_stim(); cycle(4'b1111, 1'b1, 1'b0); end
        #2 rst_in = 1'b0;
        #1;
        check("arst_en", 64'(bus_en), 64'(0));
        check("arst_ready", 64'(src_ready), 64'hF);
        check("arst_empty", 64'(isEmpty), 64'(1));
        for (int s = 0; s < 4; s++) sb[s].delete();
        @(negedge clk_in);
        rst_in = 1'b1;

        // random traffic
        for (int i = 0; i < 300; i++) begin
            gen_stim();
            cycle(4'($urandom), $urandom_range(0, 9) != 0, $urandom_range(0, 29) == 0);
        end
        for (int i = 0; i < 6; i++) begin gen_stim(); cycle(4'b0000, 1'b1, 1'b0); end
        check("final_drain", 64'(model_empty()), 64'(1));
        check("final_empty", 64'(isEmpty), 64'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
